// File: rtl/prbs_word_engine.sv
// W-bit-per-clock PRBS engine: word generator with seed load, plus a
// self-synchronising checker with lock FSM and saturating error counter.
module prbs_word_engine #(
   parameter int W        = 12,
   parameter int LOCK_CNT = 4,
   parameter int ERR_THR  = 3,
   parameter int CW       = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          MODE,
   input  logic [2:0]    POLY,
   input  logic          SEED_LD,
   input  logic [W-1:0]  SEED,
   input  logic          EN,
   input  logic [W-1:0]  DIN,
   input  logic          DIN_VLD,
   input  logic          CNT_CLR,
   output logic [W-1:0]  DOUT,
   output logic          DOUT_VLD,
   output logic          LOCKED,
   output logic          ERR_PULSE,
   output logic [CW-1:0] ERR_CNT,
   output logic          CFG_ERR
);

   // Scratch width wide enough to reach the highest tap (x^31) for any W.
   localparam int WX  = (W > 31) ? W : 31;
   localparam int MW  = $clog2(LOCK_CNT + 1);
   localparam int XW  = $clog2(ERR_THR + 1);

   typedef enum logic [1:0] {ST_SEED, ST_SYNC, ST_LOCKED} state_t;

   // W single-bit LFSR steps: shift left, new LSB = win[N-1] ^ win[M-1].
   function automatic logic [W-1:0] advance(input logic [W-1:0] s, input logic [2:0] p);
      logic [WX-1:0] t;
      logic          fb;
      t = WX'(s);
      for (int i = 0; i < W; i++) begin
         case (p)
            3'd0:    fb = t[6]  ^ t[5];
            3'd1:    fb = t[8]  ^ t[4];
            3'd2:    fb = t[14] ^ t[13];
            3'd3:    fb = t[22] ^ t[17];
            3'd4:    fb = t[30] ^ t[27];
            default: fb = 1'b0;
         endcase
         t = {t[WX-2:0], fb};
      end
      return t[W-1:0];
   endfunction

   logic [W-1:0]  win_q, win_d, dout_q, dout_d, pred_q, pred_d;
   logic          dout_vld_q, dout_vld_d, err_pulse_q, err_pulse_d;
   logic [MW-1:0] matches_q, matches_d, matches_inc;
   logic [XW-1:0] misses_q, misses_d, misses_inc;
   logic [CW-1:0] err_cnt_q, err_cnt_d;
   state_t        state_q, state_d;
   logic [WX-1:0] ord_mask;
   logic          ord_ok, cfg_err, seed_zero, din_zero, err_inc;
   logic [W-1:0]  gen_adv, din_adv, pred_adv;

   // Polynomial decode: low-N-bit mask for zero detection and order legality.
   always_comb begin
      ord_mask = '0;
      ord_ok   = 1'b0;
      case (POLY)
         3'd0: begin ord_mask = WX'(64'h7F);       ord_ok = (W >= 7);  end
         3'd1: begin ord_mask = WX'(64'h1FF);      ord_ok = (W >= 9);  end
         3'd2: begin ord_mask = WX'(64'h7FFF);     ord_ok = (W >= 15); end
         3'd3: begin ord_mask = WX'(64'h7FFFFF);   ord_ok = (W >= 23); end
         3'd4: begin ord_mask = WX'(64'h7FFFFFFF); ord_ok = (W >= 31); end
         default: begin ord_mask = '0;             ord_ok = 1'b0;      end
      endcase
      cfg_err   = ~ord_ok;
      seed_zero = ((WX'(SEED) & ord_mask) == '0);
      din_zero  = ((WX'(DIN) & ord_mask) == '0);
      gen_adv   = advance(win_q, POLY);
      din_adv   = advance(DIN, POLY);
      pred_adv  = advance(pred_q, POLY);
   end

   // Generator next state: seed load wins over advance; DOUT holds when idle.
   always_comb begin
      win_d      = win_q;
      dout_d     = dout_q;
      dout_vld_d = 1'b0;
      if (!MODE) begin
         if (SEED_LD) begin
            win_d = seed_zero ? '1 : SEED;
         end else if (EN && !cfg_err) begin
            win_d      = gen_adv;
            dout_d     = gen_adv;
            dout_vld_d = 1'b1;
         end
      end
   end

   // Checker FSM: seed from line, confirm LOCK_CNT matches, then free-run prediction.
   always_comb begin
      state_d     = state_q;
      pred_d      = pred_q;
      matches_d   = matches_q;
      misses_d    = misses_q;
      err_pulse_d = 1'b0;
      err_inc     = 1'b0;
      matches_inc = matches_q + MW'(1);
      misses_inc  = misses_q + XW'(1);
      if (!MODE || cfg_err || SEED_LD) begin
         state_d   = ST_SEED;
         matches_d = '0;
         misses_d  = '0;
      end else if (DIN_VLD) begin
         case (state_q)
            ST_SEED: begin
               if (!din_zero) begin
                  pred_d    = din_adv;
                  matches_d = '0;
                  state_d   = ST_SYNC;
               end
            end
            ST_SYNC: begin
               if (DIN == pred_q) begin
                  pred_d    = din_adv;
                  matches_d = matches_inc;
                  if (matches_inc == MW'(LOCK_CNT)) begin
                     state_d  = ST_LOCKED;
                     misses_d = '0;
                  end
               end else if (!din_zero) begin
                  pred_d    = din_adv;
                  matches_d = '0;
               end else begin
                  state_d   = ST_SEED;
                  matches_d = '0;
               end
            end
            ST_LOCKED: begin
               // Prediction runs from itself so a corrupted word cannot poison it.
               pred_d = pred_adv;
               if (DIN != pred_q) begin
                  err_pulse_d = 1'b1;
                  err_inc     = 1'b1;
                  misses_d    = misses_inc;
                  if (misses_inc == XW'(ERR_THR)) begin
                     state_d  = ST_SEED;
                     misses_d = '0;
                  end
               end else begin
                  misses_d = '0;
               end
            end
            default: state_d = ST_SEED;
         endcase
      end
   end

   // Error counter: clear beats a coincident increment; saturates at all-ones.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (CNT_CLR) begin
         err_cnt_d = '0;
      end else if (err_inc && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + CW'(1);
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         win_q       <= '1;
         dout_q      <= '0;
         dout_vld_q  <= 1'b0;
         pred_q      <= '0;
         matches_q   <= '0;
         misses_q    <= '0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
         state_q     <= ST_SEED;
      end else begin
         win_q       <= win_d;
         dout_q      <= dout_d;
         dout_vld_q  <= dout_vld_d;
         pred_q      <= pred_d;
         matches_q   <= matches_d;
         misses_q    <= misses_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q   <= err_cnt_d;
         state_q     <= state_d;
      end
   end

   assign DOUT      = dout_q;
   assign DOUT_VLD  = dout_vld_q & ~cfg_err;
   assign LOCKED    = (state_q == ST_LOCKED) & ~cfg_err;
   assign ERR_PULSE = err_pulse_q & ~cfg_err;
   assign ERR_CNT   = err_cnt_q;
   assign CFG_ERR   = cfg_err;

endmodule
